// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of one shared binary<->Gray converter.
// Optional handshake counter: define GRAY_CONV_ARB_STATS_EN.
module gray_conv_arbiter #(
  parameter int VEC_W   = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*VEC_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_mode_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [VEC_W-1:0]         rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     rsp_mode_o,
  output logic                     busy_o
`ifdef GRAY_CONV_ARB_STATS_EN
  ,
  input  logic                     stats_clr_i,
  output logic [15:0]              conv_cnt_o
`endif
);
  // Shares one converter among NUM_REQ clients, round-robin from the last winner + 1.
  // Latency: 1 cycle from request transfer to rsp_valid_o; 1 response/cycle sustained.
  // Backpressure: a held response (rsp_ready_i low) stalls every requester.

  typedef struct packed {
    logic [VEC_W-1:0] dat;
    logic [ID_W-1:0]  id;
    logic             mode;
  } rsp_t;

  function automatic logic [VEC_W-1:0] bin2gray(input logic [VEC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [VEC_W-1:0] gray2bin(input logic [VEC_W-1:0] g);
    logic [VEC_W-1:0] b;
    b[VEC_W-1] = g[VEC_W-1];
    for (int i = VEC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             can_accept;
  logic             xfer;
  logic [VEC_W-1:0] sel_dat;
  logic             sel_mode;
  rsp_t             rsp_q;
  rsp_t             rsp_d;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign can_accept = !rsp_valid_o || rsp_ready_i;
  assign xfer       = gnt_vld && can_accept;

  always_comb begin
    req_ready_o         = '0;
    req_ready_o[gnt_id] = xfer;
  end

  assign sel_dat  = req_data_i[gnt_id*VEC_W +: VEC_W];
  assign sel_mode = req_mode_i[gnt_id];

  always_comb begin
    rsp_d.dat  = sel_mode ? gray2bin(sel_dat) : bin2gray(sel_dat);
    rsp_d.id   = gnt_id;
    rsp_d.mode = sel_mode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_o <= 1'b0;
      rsp_q       <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      rsp_valid_o <= 1'b1;
      rsp_q       <= rsp_d;
      ptr         <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  assign rsp_data_o = rsp_q.dat;
  assign rsp_id_o   = rsp_q.id;
  assign rsp_mode_o = rsp_q.mode;
  assign busy_o     = rsp_valid_o;

`ifdef GRAY_CONV_ARB_STATS_EN
  // Clear wins over a same-cycle handshake; the count saturates rather than wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_cnt_o <= '0;
    end else if (stats_clr_i) begin
      conv_cnt_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i && conv_cnt_o != 16'hFFFF) begin
      conv_cnt_o <= conv_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter (VEC_W=4, NUM_REQ=4).
module tb_gray_conv_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [15:0] req_data;
  logic [3:0] req_mode;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [1:0] rsp_id;
  logic       rsp_mode;
  logic       busy;
`ifdef GRAY_CONV_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] conv_cnt;
`endif

  int errors = 0;
  int checks = 0;

  gray_conv_arbiter #(.VEC_W(4), .NUM_REQ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_mode_i  (req_mode),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_mode_o  (rsp_mode),
    .busy_o      (busy)
`ifdef GRAY_CONV_ARB_STATS_EN
    ,
    .stats_clr_i (stats_clr),
    .conv_cnt_o  (conv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_data = '0; req_mode = '0; rsp_ready = 1'b1;
`ifdef GRAY_CONV_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 4'b0000) begin errors++; $display("FAIL reset_data got=%b exp=0000", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got=%b exp=0", rsp_mode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
`ifdef GRAY_CONV_ARB_STATS_EN
    checks++; if (conv_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", conv_cnt); end
`endif
    reset = 1'b0;
  endtask

  // req0 1011 bin->Gray = 1110; pointer moves to 1.
  task automatic test_single_b2g();
    req_valid = 4'b0001; req_data = 16'h000B; req_mode = 4'b0000; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2g_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2g_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 4'b1110) begin errors++; $display("FAIL b2g_data got=%b exp=1110", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL b2g_id got=%0d exp=0", rsp_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2g_busy got=%b exp=1", busy); end
  endtask

  // req2 Gray 1110 -> 1011; afterwards the search starts at 3 (0000 bin->Gray = 0000).
  task automatic test_single_g2b();
    req_valid = 4'b0100; req_data = 16'h0E00; req_mode = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL g2b_ready got=%b exp=0100", req_ready); end
    tick();
    checks++; if (rsp_data !== 4'b1011) begin errors++; $display("FAIL g2b_data got=%b exp=1011", rsp_data); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL g2b_id got=%0d exp=2", rsp_id); end
    checks++; if (rsp_mode !== 1'b1) begin errors++; $display("FAIL g2b_mode got=%b exp=1", rsp_mode); end
    req_valid = 4'b1111; req_data = 16'h0000; req_mode = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL g2b_next_ptr got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL zero_b2g_id got=%0d exp=3", rsp_id); end
    checks++; if (rsp_data !== 4'b0000) begin errors++; $display("FAIL zero_b2g_data got=%b exp=0000", rsp_data); end
  endtask

  // Pointer is 0 here. req0 bin 1111->1000, req1 Gray 1000->1111,
  // req2 Gray 0000->0000, req3 bin 0101->0111.
  task automatic test_back_to_back();
    logic [1:0] exp_id [6];
    logic [3:0] exp_dat [4];
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{4'b1000, 4'b1111, 4'b0000, 4'b0111};
    req_valid = 4'b1111; req_data = 16'h5_0_8_F; req_mode = 4'b0110; rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", n, rsp_valid); end
      checks++; if (rsp_id !== exp_id[n]) begin errors++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", n, rsp_id, exp_id[n]); end
      checks++; if (rsp_data !== exp_dat[exp_id[n]]) begin errors++; $display("FAIL b2b_data[%0d] got=%b exp=%b", n, rsp_data, exp_dat[exp_id[n]]); end
    end
  endtask

  // Held response from req1 (1111); pointer is 2.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", n, req_ready); end
      checks++; if (rsp_id !== 2'd1 || rsp_data !== 4'b1111) begin errors++; $display("FAIL bp_hold[%0d] got=%0d/%b exp=1/1111", n, rsp_id, rsp_data); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL bp_refill got=%b/%0d exp=1/2", rsp_valid, rsp_id); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
  endtask

  // Pointer is 3, so req3 wins first; reset then sends the pointer back to 0.
  task automatic test_reset_mid();
    req_valid = 4'b1010; rsp_ready = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/3", rsp_valid, rsp_id); end
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0 || rsp_data !== 4'b0000) begin errors++; $display("FAIL mid_async_clear got=%b/%b exp=0/0000", busy, rsp_data); end
`ifdef GRAY_CONV_ARB_STATS_EN
    checks++; if (conv_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", conv_cnt); end
`endif
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_id !== 2'd1 || rsp_data !== 4'b1111 || rsp_mode !== 1'b1) begin errors++; $display("FAIL mid_rsp got=%0d/%b/%b exp=1/1111/1", rsp_id, rsp_data, rsp_mode); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_b2g();
    test_single_g2b();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
